// File: rtl/axi_rom_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_rom_responder : AXI4 read-only slave serving AR/R bursts from a word RAM
//                     that is loaded through a side write port.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module axi_rom_responder #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int MEM_ADDR_BITS      = 12,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h2000_0000
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]                    S_AXI_ARLEN,
    input  logic [2:0]                    S_AXI_ARSIZE,
    input  logic [1:0]                    S_AXI_ARBURST,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RLAST,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    input  logic                          LD_WE,
    input  logic [MEM_ADDR_BITS-3:0]      LD_ADDR,
    input  logic [31:0]                   LD_DATA
);

    localparam int IW    = MEM_ADDR_BITS - 2;
    localparam int WORDS = 2 ** IW;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [0:0]                  state_q, state_d;
    logic                        arready_q, arready_d;
    logic [C_S_AXI_ID_WIDTH-1:0] id_q, id_d;
    logic [7:0]                  len_q, len_d;
    logic                        fixed_q, fixed_d;
    logic [1:0]                  resp_q, resp_d;
    logic [IW-1:0]               fetch_q, fetch_d;
    logic [7:0]                  issue_idx_q, issue_idx_d;
    logic                        issue_done_q, issue_done_d;
    logic                        pend_q, pend_d;
    logic                        pend_last_q, pend_last_d;
    logic [1:0]                  cnt_q, cnt_d;
    logic [1:0][31:0]            ent_data_q, ent_data_d;
    logic [1:0][1:0]             ent_resp_q, ent_resp_d;
    logic [1:0]                  ent_last_q, ent_last_d;

    logic [31:0]   mem_q [WORDS];
    logic [31:0]   rdata_q;
    logic [IW-1:0] rd_addr;
    logic          ar_hs;
    logic          pop;
    logic          wr_slot;
    logic [1:0]    ar_resp;

    assign ar_hs = S_AXI_ARVALID && arready_q;
    assign pop   = (cnt_q != 2'd0) && S_AXI_RREADY;

    // Read-before-write RAM: a same-cycle load of the word being read returns old data
    always_ff @(posedge CLK) begin
        if (LD_WE) begin
            mem_q[LD_ADDR] <= LD_DATA;
        end
        rdata_q <= mem_q[rd_addr];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            arready_q    <= 1'b0;
            id_q         <= '0;
            len_q        <= 8'd0;
            fixed_q      <= 1'b0;
            resp_q       <= RESP_OKAY;
            fetch_q      <= '0;
            issue_idx_q  <= 8'd0;
            issue_done_q <= 1'b1;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            cnt_q        <= 2'd0;
            ent_data_q   <= '0;
            ent_resp_q   <= '0;
            ent_last_q   <= '0;
        end else begin
            state_q      <= state_d;
            arready_q    <= arready_d;
            id_q         <= id_d;
            len_q        <= len_d;
            fixed_q      <= fixed_d;
            resp_q       <= resp_d;
            fetch_q      <= fetch_d;
            issue_idx_q  <= issue_idx_d;
            issue_done_q <= issue_done_d;
            pend_q       <= pend_d;
            pend_last_q  <= pend_last_d;
            cnt_q        <= cnt_d;
            ent_data_q   <= ent_data_d;
            ent_resp_q   <= ent_resp_d;
            ent_last_q   <= ent_last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ar_hs) state_d = S_BURST;
            S_BURST: if (pop && ent_last_q[0]) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Response class is decided once per burst; DECERR outranks SLVERR
    always_comb begin
        ar_resp = RESP_OKAY;
        if (S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:MEM_ADDR_BITS] !=
            BASE_ADDR[C_S_AXI_ADDR_WIDTH-1:MEM_ADDR_BITS]) begin
            ar_resp = RESP_DECERR;
        end else if ((S_AXI_ARSIZE != 3'b010) || S_AXI_ARBURST[1] ||
                     (S_AXI_ARADDR[1:0] != 2'b00)) begin
            ar_resp = RESP_SLVERR;
        end
    end

    // Fetch side: the first word is read in the handshake cycle, later words only
    // when the skid buffer is guaranteed room for them.
    always_comb begin
        id_d         = id_q;
        len_d        = len_q;
        fixed_d      = fixed_q;
        resp_d       = resp_q;
        fetch_d      = fetch_q;
        issue_idx_d  = issue_idx_q;
        issue_done_d = issue_done_q;
        pend_d       = 1'b0;
        pend_last_d  = 1'b0;
        rd_addr      = fetch_q;
        arready_d    = (state_d == S_IDLE);
        if (ar_hs) begin
            id_d         = S_AXI_ARID;
            len_d        = S_AXI_ARLEN;
            fixed_d      = (S_AXI_ARBURST == 2'b00);
            resp_d       = ar_resp;
            rd_addr      = S_AXI_ARADDR[MEM_ADDR_BITS-1:2];
            pend_d       = 1'b1;
            pend_last_d  = (S_AXI_ARLEN == 8'd0);
            issue_done_d = (S_AXI_ARLEN == 8'd0);
            issue_idx_d  = 8'd1;
            fetch_d      = S_AXI_ARADDR[MEM_ADDR_BITS-1:2] +
                           {{(IW-1){1'b0}}, (S_AXI_ARBURST != 2'b00)};
        end else if ((state_q == S_BURST) && !issue_done_q &&
                     (({1'b0, cnt_q} + {2'b00, pend_q}) < (3'd2 + {2'b00, pop}))) begin
            pend_d       = 1'b1;
            pend_last_d  = (issue_idx_q == len_q);
            issue_done_d = (issue_idx_q == len_q);
            issue_idx_d  = issue_idx_q + 8'd1;
            fetch_d      = fetch_q + {{(IW-1){1'b0}}, ~fixed_q};
        end
    end

    // Two-entry skid buffer, entry 0 is the head presented on R
    always_comb begin
        ent_data_d = ent_data_q;
        ent_resp_d = ent_resp_q;
        ent_last_d = ent_last_q;
        wr_slot    = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && !pop);
        if (pop) begin
            ent_data_d[0] = ent_data_q[1];
            ent_resp_d[0] = ent_resp_q[1];
            ent_last_d[0] = ent_last_q[1];
        end
        if (pend_q) begin
            ent_data_d[wr_slot] = (resp_q == RESP_OKAY) ? rdata_q : 32'h0;
            ent_resp_d[wr_slot] = resp_q;
            ent_last_d[wr_slot] = pend_last_q;
        end
        cnt_d = cnt_q + {1'b0, pend_q} - {1'b0, pop};
    end

    always_comb begin
        S_AXI_ARREADY = arready_q;
        S_AXI_RVALID  = (cnt_q != 2'd0);
        S_AXI_RID     = id_q;
        S_AXI_RDATA   = S_AXI_RVALID ? ent_data_q[0] : 32'h0;
        S_AXI_RRESP   = S_AXI_RVALID ? ent_resp_q[0] : RESP_OKAY;
        S_AXI_RLAST   = S_AXI_RVALID && ent_last_q[0];
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_rom_responder.sv
`default_nettype none
// tb_axi_rom_responder : directed and randomized bursts against a
// word-level reference model of the ROM responder.
`timescale 1ns/1ps
module tb_axi_rom_responder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [0:0]  S_AXI_ARID;
    logic [31:0] S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic [2:0]  S_AXI_ARSIZE;
    logic [1:0]  S_AXI_ARBURST;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [0:0]  S_AXI_RID;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        LD_WE;
    logic [9:0]  LD_ADDR;
    logic [31:0] LD_DATA;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_mem [1024];

    always #5 CLK = ~CLK;

    axi_rom_responder dut (
        .CLK(CLK), .RST(RST),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .LD_WE(LD_WE), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] rbus();
        return {S_AXI_RID, S_AXI_RLAST, S_AXI_RRESP, S_AXI_RDATA};
    endfunction

    // Expected {RID, RLAST, RRESP, RDATA} of beat i, straight from the address/response rules
    function automatic logic [35:0] exp_beat(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input logic [0:0] id, input int i);
        logic [1:0]  resp;
        int          widx;
        logic [31:0] data;
        if (addr[31:12] != 20'h20000)
            resp = 2'b11;
        else if (size != 3'b010 || burst > 2'b01 || addr[1:0] != 2'b00)
            resp = 2'b10;
        else
            resp = 2'b00;
        widx = (burst == 2'b00) ? int'(addr[11:2]) : (int'(addr[11:2]) + i) % 1024;
        data = (resp == 2'b00) ? model_mem[widx] : 32'h0;
        return {id, (i == int'(len)), resp, data};
    endfunction

    // mode 0: RREADY=1, 1: pattern 1,0,0,1, 2: random. ld_rel>=0 writes word 5 in cycle T+ld_rel.
    task automatic run_burst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [0:0] id,
                             input int mode, input int ld_rel, input logic [31:0] ld_val);
        logic [35:0] expq [$];
        logic [35:0] held;
        logic        was_stall;
        int          beat, rel, first_rel, last_rel, t;
        for (int i = 0; i <= int'(len); i++)
            expq.push_back(exp_beat(addr, len, size, burst, id, i));
        S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len;
        S_AXI_ARSIZE = size; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
        t = 0;
        while (S_AXI_ARREADY !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        if (t >= 20) begin
            check({tag, " arready timeout"}, 64'(S_AXI_ARREADY), 64'd1);
            S_AXI_ARVALID = 1'b0;
            return;
        end
        step();
        S_AXI_ARVALID = 1'b0;
        rel = 1; beat = 0; first_rel = -1; last_rel = -1; was_stall = 1'b0; held = '0;
        while (beat <= int'(len) && rel < 64 + 8 * int'(len)) begin
            case (mode)
                0:       S_AXI_RREADY = 1'b1;
                1:       S_AXI_RREADY = (rel % 4 == 0) || (rel % 4 == 3);
                default: S_AXI_RREADY = 1'($urandom_range(0, 1));
            endcase
            LD_WE = (rel == ld_rel); LD_ADDR = 10'd5; LD_DATA = ld_val;
            if (was_stall)
                check({tag, " hold"}, 64'({S_AXI_RVALID, rbus()}), 64'({1'b1, held}));
            was_stall = 1'b0;
            if (S_AXI_RVALID) begin
                if (first_rel < 0) first_rel = rel;
                if (S_AXI_RREADY) begin
                    check($sformatf("%s beat%0d", tag, beat), 64'(rbus()), 64'(expq[beat]));
                    beat++;
                    last_rel = rel;
                end else begin
                    held = rbus();
                    was_stall = 1'b1;
                end
            end
            step();
            rel++;
        end
        S_AXI_RREADY = 1'b0;
        LD_WE = 1'b0;
        check({tag, " beat count"}, 64'(beat), 64'(int'(len) + 1));
        check({tag, " first latency"}, 64'(first_rel), 64'd2);
        if (mode == 0)
            check({tag, " last beat cycle"}, 64'(last_rel), 64'(int'(len) + 2));
        check({tag, " idle after"}, 64'({S_AXI_ARREADY, S_AXI_RVALID}), 64'(2'b10));
        if (ld_rel >= 0) model_mem[5] = ld_val;
    endtask

    initial begin
        int t, beat;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [1:0]  bt;
        S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = 3'b010;
        S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        LD_WE = 1'b0; LD_ADDR = '0; LD_DATA = '0;
        RST = 1'b1;
        step();
        step();
        check("reset arready", 64'(S_AXI_ARREADY), 64'd0);
        check("reset r channel", 64'({S_AXI_RVALID, rbus()}), 64'd0);
        RST = 1'b0;

        for (int i = 0; i < 1024; i++) begin
            LD_WE = 1'b1; LD_ADDR = 10'(i); LD_DATA = 32'h1000_0000 + 32'(i);
            model_mem[i] = 32'h1000_0000 + 32'(i);
            step();
        end
        LD_WE = 1'b0;
        step();
        check("idle arready", 64'(S_AXI_ARREADY), 64'd1);

        run_burst("t1 incr32",   32'h2000_0000, 8'd31, 3'b010, 2'b01, 1'b1, 0, -1, 32'h0);
        run_burst("t2 rready",   32'h2000_0000, 8'd31, 3'b010, 2'b01, 1'b0, 1, -1, 32'h0);
        run_burst("t3 wrap",     32'h2000_0FF8, 8'd3,  3'b010, 2'b01, 1'b1, 0, -1, 32'h0);
        run_burst("t3 fixed",    32'h2000_0010, 8'd3,  3'b010, 2'b00, 1'b0, 2, -1, 32'h0);
        run_burst("t4 decerr",   32'h3000_0000, 8'd1,  3'b010, 2'b01, 1'b1, 0, -1, 32'h0);
        run_burst("t4 size",     32'h2000_0000, 8'd1,  3'b001, 2'b01, 1'b0, 0, -1, 32'h0);
        run_burst("t4 wrapbt",   32'h2000_0040, 8'd2,  3'b010, 2'b10, 1'b1, 2, -1, 32'h0);
        run_burst("t4 unalign",  32'h2000_0042, 8'd0,  3'b010, 2'b01, 1'b0, 0, -1, 32'h0);
        run_burst("t4 decprio",  32'h4000_0002, 8'd0,  3'b001, 2'b11, 1'b1, 0, -1, 32'h0);

        // Reset while beat 10 of a 32-beat burst is on the bus
        S_AXI_ARID = 1'b0; S_AXI_ARADDR = 32'h2000_0000; S_AXI_ARLEN = 8'd31;
        S_AXI_ARSIZE = 3'b010; S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        t = 0;
        while (S_AXI_ARREADY !== 1'b1 && t < 20) begin step(); t++; end
        step();
        S_AXI_ARVALID = 1'b0;
        beat = 0; t = 0;
        while (beat < 10 && t < 100) begin
            if (S_AXI_RVALID) beat++;
            step();
            t++;
        end
        check("t5 beat10 on bus", 64'(rbus()), 64'(exp_beat(32'h2000_0000, 8'd31, 3'b010, 2'b01, 1'b0, 10)));
        RST = 1'b1;
        step();
        RST = 1'b0;
        S_AXI_RREADY = 1'b0;
        check("t5 rvalid drop", 64'(S_AXI_RVALID), 64'd0);
        t = 0;
        while (S_AXI_ARREADY !== 1'b1 && t < 4) begin step(); t++; end
        check("t5 arready back", 64'(S_AXI_ARREADY), 64'd1);
        run_burst("t5 preserved", 32'h2000_0000, 8'd7, 3'b010, 2'b01, 1'b1, 0, -1, 32'h0);

        run_burst("t6 same cyc", 32'h2000_0000, 8'd7, 3'b010, 2'b01, 1'b0, 0, 5, 32'hDEAD_BEEF);
        run_burst("t6 new val",  32'h2000_0000, 8'd7, 3'b010, 2'b01, 1'b1, 0, -1, 32'h0);

        for (int n = 0; n < 16; n++) begin
            for (int k = 0; k < 3; k++) begin
                LD_WE = 1'b1; LD_ADDR = 10'($urandom); LD_DATA = $urandom;
                model_mem[LD_ADDR] = LD_DATA;
                step();
            end
            LD_WE = 1'b0;
            a = {20'h20000, 10'($urandom), 2'b00};
            if ($urandom_range(0, 9) == 0) a[31:28] = 4'(3'($urandom) + 4'd3);
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom);
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b010;
            bt = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'($urandom_range(0, 1));
            run_burst($sformatf("rand%0d", n), a, 8'($urandom_range(0, 40)), sz, bt,
                      1'($urandom), 2, -1, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
